// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg -- shared types and constants for the dp_sequencer microcode
// sequencer.
//   op_e    : micro-instruction opcode (word bits [15:14])
//   state_e : sequencer FSM states
//   mcode_t : 14-bit datapath control word layout
// Optional feature macro used by the sequencer: DP_SEQ_STEP_LIMIT_EN.
package dp_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned MC_W    = 14;

    // machineCode field positions
    localparam int unsigned MC_RFSRC_BIT   = 13;
    localparam int unsigned MC_RADDR1_LSB  = 10;
    localparam int unsigned MC_RADDR2_LSB  = 7;
    localparam int unsigned MC_WADDR_LSB   = 4;
    localparam int unsigned MC_WREN_BIT    = 3;
    localparam int unsigned MC_ALUOP_LSB   = 1;
    localparam int unsigned MC_OUTLOAD_BIT = 0;

    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_JLE  = 2'b01,
        OP_JMP  = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       rf_src;
        logic [2:0] raddr1;
        logic [2:0] raddr2;
        logic [2:0] waddr;
        logic       wr_en;
        logic [1:0] alu_op;
        logic       out_load;
    } mcode_t;

    // Keeps the register read addresses live (so the datapath still
    // evaluates le) while removing any write, ALU op or output load.
    function automatic mcode_t mcode_ctrl_off(input logic [MC_W-1:0] field);
        logic [MC_W-1:0] w;
        w = field;
        w[MC_WREN_BIT]         = 1'b0;
        w[MC_ALUOP_LSB +: 2]   = 2'b00;
        w[MC_OUTLOAD_BIT]      = 1'b0;
        return mcode_t'(w);
    endfunction

endpackage

// File: rtl/dp_seq_prog_mem.sv
// dp_seq_prog_mem -- microprogram store for dp_sequencer.
// DEPTH x 16 register array, synchronous write, asynchronous read, no reset.
//   clk     : write clock
//   i_we    : write strobe
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module dp_seq_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer -- programmable microcode sequencer driving the
// register-file/ALU datapath control word.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : run request (accepted in IDLE only)
//   le             : datapath comparator flag, used by JLE
//   prog_we/addr/wdata : program write port (IDLE only)
//   machineCode    : 14-bit control word (0 outside RUN)
//   busy           : high while running
//   done           : one-cycle pulse at end of run
//   err            : run ended by step limit, held until next start
//   pc             : program counter (debug)
// Optional feature: define DP_SEQ_STEP_LIMIT_EN to abort runs that reach
// MAX_STEPS RUN cycles without executing HALT.
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter logic [7:0]  MAX_STEPS  = 8'd255,
    localparam int unsigned AW        = $clog2(PROG_DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            le,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [15:0]     prog_wdata,
    output logic [13:0]     machineCode,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   pc
);

    state_e          r_state;
    logic [AW-1:0]   r_pc;
    logic [15:0]     w_instr;
    op_e             w_op;
    logic [13:0]     w_field;
    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_target;
    logic            w_run;
    logic            w_mem_we;
    logic            w_limit;
    mcode_t          w_mc;

    assign w_run    = (r_state == S_RUN);
    assign w_mem_we = prog_we && (r_state == S_IDLE);

    dp_seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

    assign w_op     = op_e'(w_instr[15:14]);
    assign w_field  = w_instr[13:0];
    assign w_target = w_field[AW-1:0];
    assign w_pc_inc = r_pc + 1'b1;  // PROG_DEPTH is a power of two: wraps naturally

`ifdef DP_SEQ_STEP_LIMIT_EN
    logic [7:0] r_steps;
    logic       r_err;

    // Limit fires in the MAX_STEPS-th RUN cycle of a run.
    assign w_limit = w_run && ((r_steps + 8'd1) == MAX_STEPS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_steps <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_steps <= '0;
                r_err   <= 1'b0;
            end
        end else if (w_run) begin
            r_steps <= r_steps + 8'd1;
            if (w_limit && (w_op != OP_HALT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_max_steps;

    assign w_unused_max_steps = ^MAX_STEPS;
    assign w_limit            = 1'b0;
    assign err                = 1'b0;
`endif

    // Control word decode; HALT wins over the step limit.
    always_comb begin
        w_mc = '0;
        if (w_run) begin
            if (w_op == OP_EXEC) begin
                w_mc = mcode_t'(w_field);
            end else begin
                w_mc = mcode_ctrl_off(w_field);
            end
            if (w_limit && (w_op != OP_HALT)) begin
                w_mc = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_op == OP_HALT || w_limit) begin
                        r_state <= S_DONE;
                    end else begin
                        case (w_op)
                            OP_JLE:  r_pc <= le ? w_target : w_pc_inc;
                            OP_JMP:  r_pc <= w_target;
                            default: r_pc <= w_pc_inc;
                        endcase
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign machineCode = w_mc;
    assign busy        = w_run;
    assign done        = (r_state == S_DONE);
    assign pc          = r_pc;

endmodule

// File: tb/tb_dp_sequencer.sv
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, le, prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic [13:0] machineCode;
    logic        busy, done, err;
    logic [3:0]  pc;

    // two PROG_DEPTH=4 instances sharing a program port
    logic        start4, we4;
    logic [1:0]  addr4;
    logic [13:0] mc4, mcL;
    logic        busy4, done4, err4, busyL, doneL, errL;
    logic [1:0]  pc4, pcL;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    dp_sequencer #(.PROG_DEPTH(16), .MAX_STEPS(8'd200)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .le(le),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .machineCode(machineCode), .busy(busy), .done(done), .err(err), .pc(pc)
    );

    dp_sequencer #(.PROG_DEPTH(4), .MAX_STEPS(8'd255)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .le(le),
        .prog_we(we4), .prog_addr(addr4), .prog_wdata(prog_wdata),
        .machineCode(mc4), .busy(busy4), .done(done4), .err(err4), .pc(pc4)
    );

    dp_sequencer #(.PROG_DEPTH(4), .MAX_STEPS(8'd5)) dutL (
        .clk(clk), .reset_n(reset_n), .start(start4), .le(le),
        .prog_we(we4), .prog_addr(addr4), .prog_wdata(prog_wdata),
        .machineCode(mcL), .busy(busyL), .done(doneL), .err(errL), .pc(pcL)
    );

    typedef struct {
        logic        st;
        logic        le;
        logic [13:0] mc;
        logic        busy;
        logic        done;
        logic        chk_pc;
        logic [3:0]  pc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic s, input logic l, input logic [13:0] m,
                               input logic b, input logic d, input logic cp,
                               input logic [3:0] p);
        vec_t r;
        r.st = s; r.le = l; r.mc = m; r.busy = b; r.done = d; r.chk_pc = cp; r.pc = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wr4(input logic [1:0] a, input logic [15:0] d);
        we4 = 1'b1; addr4 = a; prog_wdata = d;
        tick();
        we4 = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Rows are applied at successive negedges; start/le drive the next edge.
    task automatic run_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            start = tv[i].st;
            le    = tv[i].le;
            chk($sformatf("%s[%0d].mc", tag, i - first), 32'(machineCode), 32'(tv[i].mc));
            chk($sformatf("%s[%0d].busy", tag, i - first), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("%s[%0d].done", tag, i - first), 32'(done), 32'(tv[i].done));
            if (tv[i].chk_pc)
                chk($sformatf("%s[%0d].pc", tag, i - first), 32'(pc), 32'(tv[i].pc));
            tick();
        end
        start = 1'b0;
        le    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  epc[8];
        logic [13:0] emc[8];

        // straight line + start held through DONE: rows 0..10
        tv.push_back(v(1, 0, 14'h0000, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 14'h0018, 1, 0, 1, 0));
        tv.push_back(v(1, 0, 14'h2038, 1, 0, 1, 1));
        tv.push_back(v(1, 0, 14'h0000, 1, 0, 1, 2));
        tv.push_back(v(1, 0, 14'h0000, 0, 1, 0, 0));
        tv.push_back(v(1, 0, 14'h0000, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 14'h0018, 1, 0, 1, 0));
        tv.push_back(v(0, 0, 14'h2038, 1, 0, 1, 1));
        tv.push_back(v(0, 0, 14'h0000, 1, 0, 1, 2));
        tv.push_back(v(0, 0, 14'h0000, 0, 1, 0, 0));
        tv.push_back(v(0, 0, 14'h0000, 0, 0, 0, 0));
        // loop with JLE: rows 11..21
        tv.push_back(v(1, 0, 14'h0000, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 14'h0598, 1, 0, 1, 0));
        tv.push_back(v(0, 1, 14'h0500, 1, 0, 1, 1));
        tv.push_back(v(0, 0, 14'h0598, 1, 0, 1, 0));
        tv.push_back(v(0, 1, 14'h0500, 1, 0, 1, 1));
        tv.push_back(v(0, 0, 14'h0598, 1, 0, 1, 0));
        tv.push_back(v(0, 0, 14'h0500, 1, 0, 1, 1));
        tv.push_back(v(0, 0, 14'h0001, 1, 0, 1, 2));
        tv.push_back(v(0, 0, 14'h1C00, 1, 0, 1, 3));
        tv.push_back(v(0, 0, 14'h0000, 0, 1, 0, 0));
        tv.push_back(v(0, 0, 14'h0000, 0, 0, 0, 0));

        reset_n = 1'b0; start = 1'b0; le = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; start4 = 1'b0; we4 = 1'b0; addr4 = '0;
        tick(); tick();
        chk("rst.mc", 32'(machineCode), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.pc", 32'(pc), 32'h0);
        reset_n = 1'b1;
        tick();

        // straight line
        wr16(4'd0, 16'h0018);
        wr16(4'd1, 16'h2038);
        wr16(4'd2, 16'hC000);
        run_rows(0, 10, "line");

        // loop: R1=R1+R3, JLE->0 (reads R1,R2), OutLoad, HALT with live raddrs
        wr16(4'd0, 16'h0598);
        wr16(4'd1, 16'h4500);
        wr16(4'd2, 16'h0001);
        wr16(4'd3, 16'hDC0F);
        run_rows(11, 21, "loop");

        // lockout: write during RUN ignored
        wr16(4'd0, 16'h0018);
        wr16(4'd1, 16'hC000);
        start = 1'b1; tick(); start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'h0777;
        tick(); prog_we = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("lock.word0", 32'(machineCode), 32'h0018);
        tick(); tick(); tick();
        // write together with start in IDLE: new word runs first
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'h0111; start = 1'b1;
        tick(); prog_we = 1'b0; start = 1'b0;
        chk("wrstart.mc", 32'(machineCode), 32'h0111);
        chk("wrstart.pc", 32'(pc), 32'h0);
        tick(); tick(); tick();

        // reset mid-run
        for (int i = 0; i < 10; i++) wr16(4'(i), 16'(i + 1));
        wr16(4'd10, 16'hC000);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("midrst.pc_before", 32'(pc), 32'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.mc", 32'(machineCode), 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        chk("midrst.pc", 32'(pc), 32'h0);
        tick(); reset_n = 1'b1; tick();
        chk("midrst.idle_busy", 32'(busy), 32'h0);
        chk("midrst.idle_pc", 32'(pc), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        chk("midrst.restart_mc", 32'(machineCode), 32'h0001);
        pulse_reset();

        // wrap + JMP on depth-4 instance
        wr4(2'd0, 16'h0001); wr4(2'd1, 16'h0002); wr4(2'd2, 16'h0004); wr4(2'd3, 16'h8C01);
        epc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        emc = '{14'h0001, 14'h0002, 14'h0004, 14'h0C00, 14'h0002, 14'h0004, 14'h0C00, 14'h0002};
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("jmp[%0d].pc", k), 32'(pc4), 32'(epc[k]));
            chk($sformatf("jmp[%0d].mc", k), 32'(mc4), 32'(emc[k]));
            tick();
        end
        pulse_reset();
        wr4(2'd3, 16'h0008);
        epc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("wrap[%0d].pc", k), 32'(pc4), 32'(epc[k]));
            tick();
        end
        pulse_reset();

        // step limit, JMP->0 forever
        wr4(2'd0, 16'h9C00);
        start4 = 1'b1; tick(); start4 = 1'b0;
`ifdef DP_SEQ_STEP_LIMIT_EN
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lim.c%0d.mc", k), 32'(mcL), 32'h1C00);
            tick();
        end
        chk("lim.c5.mc", 32'(mcL), 32'h0);
        chk("lim.c5.busy", 32'(busyL), 32'h1);
        chk("lim.c5.err", 32'(errL), 32'h0);
        tick();
        chk("lim.c6.done", 32'(doneL), 32'h1);
        chk("lim.c6.err", 32'(errL), 32'h1);
        chk("lim.c6.busy", 32'(busyL), 32'h0);
        tick();
        chk("lim.c7.done", 32'(doneL), 32'h0);
        chk("lim.c7.err_held", 32'(errL), 32'h1);
        start4 = 1'b1; tick(); start4 = 1'b0;
        chk("lim.restart.err", 32'(errL), 32'h0);
        chk("lim.restart.busy", 32'(busyL), 32'h1);
        pulse_reset();
        // HALT in the limit cycle: pc 0,1,0,1,2
        wr4(2'd0, 16'h0001); wr4(2'd1, 16'h4000); wr4(2'd2, 16'hC000);
        start4 = 1'b1; tick(); start4 = 1'b0;
        tick(); le = 1'b1; tick(); le = 1'b0; tick(); tick();
        chk("limhalt.c5.pc", 32'(pcL), 32'h2);
        tick();
        chk("limhalt.c6.done", 32'(doneL), 32'h1);
        chk("limhalt.c6.err", 32'(errL), 32'h0);
`else
        repeat (310) tick();
        chk("nolim.busy", 32'(busyL), 32'h1);
        chk("nolim.err", 32'(errL), 32'h0);
        chk("nolim.done", 32'(doneL), 32'h0);
`endif
        pulse_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
